mem_stage_ctrl: RTL and testbench

Memory-access stage controller of the 8-bit pipelined processor. It consumes the EX/MEM pipeline register outputs, runs data-memory loads and stores over a req/ready handshake, stalls upstream stages while an access is outstanding, and produces the registered MEM/WB pipeline contents for write-back. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_timeout_ctr.sv | 32 +++
 rtl/mem_stage_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: state encoding, default widths and timeout limit shared by the MEM stage controller.
// Sizing helper for the optional timeout counter lives here too.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_REG_W   = 3;
    localparam int DEF_TIMEOUT = 15;

    // Bits needed to hold values 0..maxCount inclusive.
    function automatic int ctrWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts cycles spent waiting on memory; o_expire flags the TIMEOUT-th wait cycle.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam int CW = ctrWidth(TIMEOUT);

    logic [CW-1:0] r_count;

    // Loaded to 1 on the accept edge so the count equals the number of the current wait cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(1);
        end else if (i_count && !o_expire) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = (r_count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage of the 8-bit pipeline; runs loads/stores over req/ready and fills MEM/WB.
// Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles and raise the sticky busErr flag.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic              inRegWrite,
    input  logic [REG_W-1:0]  inRd,
    input  logic [DATA_W-1:0] inALURes,
    input  logic [DATA_W-1:0] inWriteData,
    output logic              stallOut,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memRData,
    output logic              wbValid,
    output logic              wbRegWrite,
    output logic              wbMemToReg,
    output logic [REG_W-1:0]  wbRd,
    output logic [DATA_W-1:0] wbReadData,
    output logic [DATA_W-1:0] wbALURes,
    output logic              busErr
);

    if (TIMEOUT < 1) begin : g_badTimeout
        $error("mem_stage_ctrl: TIMEOUT must be at least 1");
    end

    memState_t         r_state;
    logic [REG_W-1:0]  r_latRd;
    logic              r_latRegWrite;
    logic [DATA_W-1:0] r_latALURes;

    logic              w_isMem;
    logic              w_acceptMem;
    logic              w_inWait;
    logic [ADDR_W-1:0] w_addr;

    assign w_isMem     = inMemRead || inMemWrite;
    assign w_acceptMem = (r_state == IDLE) && inValid && w_isMem;
    assign w_inWait    = (r_state == WAIT);
    assign w_addr      = ADDR_W'(inALURes);
    assign stallOut    = w_inWait;

`ifdef MEM_TIMEOUT_EN
    logic w_expire;
    logic w_abort;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeoutCtr (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_acceptMem),
        .i_count  (w_inWait),
        .o_expire (w_expire)
    );

    // A same-cycle memReady wins over the timeout, so abort only when ready is absent.
    assign w_abort = w_inWait && !memReady && w_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            busErr <= 1'b0;
        end else if (w_abort) begin
            busErr <= 1'b1;
        end
    end
`else
    assign busErr = 1'b0;
`endif

    // Stage FSM: IDLE accepts an instruction each cycle, WAIT holds the memory request until it completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_latRd       <= '0;
            r_latRegWrite <= 1'b0;
            r_latALURes   <= '0;
            memReq        <= 1'b0;
            memWe         <= 1'b0;
            memAddr       <= '0;
            memWData      <= '0;
            wbValid       <= 1'b0;
            wbRegWrite    <= 1'b0;
            wbMemToReg    <= 1'b0;
            wbRd          <= '0;
            wbReadData    <= '0;
            wbALURes      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!inValid) begin
                        wbValid    <= 1'b0;
                        wbRegWrite <= 1'b0;
                    end else if (w_isMem) begin
                        // A set write flag wins, so read+write together behaves as a store.
                        r_latRd       <= inRd;
                        r_latRegWrite <= inRegWrite;
                        r_latALURes   <= inALURes;
                        memReq        <= 1'b1;
                        memWe         <= inMemWrite;
                        memAddr       <= w_addr;
                        memWData      <= inWriteData;
                        wbValid       <= 1'b0;
                        wbRegWrite    <= 1'b0;
                        r_state       <= WAIT;
                    end else begin
                        wbValid    <= 1'b1;
                        wbRegWrite <= inRegWrite;
                        wbMemToReg <= 1'b0;
                        wbRd       <= inRd;
                        wbALURes   <= inALURes;
                    end
                end
                WAIT: begin
                    if (memReady) begin
                        memReq     <= 1'b0;
                        wbValid    <= 1'b1;
                        wbRegWrite <= r_latRegWrite && !memWe;
                        wbMemToReg <= !memWe;
                        wbRd       <= r_latRd;
                        wbALURes   <= r_latALURes;
                        if (!memWe) begin
                            wbReadData <= memRData;
                        end
                        r_state    <= IDLE;
`ifdef MEM_TIMEOUT_EN
                    end else if (w_abort) begin
                        memReq     <= 1'b0;
                        wbValid    <= 1'b1;
                        wbRegWrite <= 1'b0;
                        wbMemToReg <= 1'b0;
                        wbRd       <= r_latRd;
                        wbALURes   <= r_latALURes;
                        r_state    <= IDLE;
`endif
                    end else begin
                        wbValid    <= 1'b0;
                        wbRegWrite <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed bench for mem_stage_ctrl with a transaction-level reference model.
// Honours MEM_TIMEOUT_EN the same way the design does.
module tb_mem_stage_ctrl;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int REG_W   = 3;
    localparam int TIMEOUT = 15;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              inValid;
    logic              inMemRead;
    logic              inMemWrite;
    logic              inRegWrite;
    logic [REG_W-1:0]  inRd;
    logic [DATA_W-1:0] inALURes;
    logic [DATA_W-1:0] inWriteData;
    logic              stallOut;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memReady;
    logic [DATA_W-1:0] memRData;
    logic              wbValid;
    logic              wbRegWrite;
    logic              wbMemToReg;
    logic [REG_W-1:0]  wbRd;
    logic [DATA_W-1:0] wbReadData;
    logic [DATA_W-1:0] wbALURes;
    logic              busErr;

    int totalChecks = 0;
    int badChecks   = 0;

    mem_stage_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inValid     (inValid),
        .inMemRead   (inMemRead),
        .inMemWrite  (inMemWrite),
        .inRegWrite  (inRegWrite),
        .inRd        (inRd),
        .inALURes    (inALURes),
        .inWriteData (inWriteData),
        .stallOut    (stallOut),
        .memReq      (memReq),
        .memWe       (memWe),
        .memAddr     (memAddr),
        .memWData    (memWData),
        .memReady    (memReady),
        .memRData    (memRData),
        .wbValid     (wbValid),
        .wbRegWrite  (wbRegWrite),
        .wbMemToReg  (wbMemToReg),
        .wbRd        (wbRd),
        .wbReadData  (wbReadData),
        .wbALURes    (wbALURes),
        .busErr      (busErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one outstanding memory transaction, everything else passes straight to write-back.
    typedef struct {
        logic [REG_W-1:0]  rd;
        logic              regWrite;
        logic [DATA_W-1:0] alu;
        logic              isStore;
    } pendTxn_t;

    pendTxn_t          pend;
    bit                mBusy = 1'b0;
    bit                mRstLast = 1'b1;
    int                mWaitCycles = 0;
    logic              mReq = 1'b0, mWe = 1'b0, mBusErr = 1'b0;
    logic [ADDR_W-1:0] mAddr = '0;
    logic [DATA_W-1:0] mWData = '0;
    logic              mWbValid = 1'b0, mWbRegWrite = 1'b0, mWbMemToReg = 1'b0;
    logic [REG_W-1:0]  mWbRd = '0;
    logic [DATA_W-1:0] mWbReadData = '0, mWbALURes = '0;

    always @(posedge clk) begin
        mRstLast = rst;
        if (rst) begin
            mBusy = 1'b0; mReq = 1'b0; mWe = 1'b0; mAddr = '0; mWData = '0;
            mWbValid = 1'b0; mWbRegWrite = 1'b0; mWbMemToReg = 1'b0; mWbRd = '0;
            mWbReadData = '0; mWbALURes = '0; mBusErr = 1'b0;
        end else if (!mBusy) begin
            if (inValid && (inMemRead || inMemWrite)) begin
                pend = '{rd: inRd, regWrite: inRegWrite, alu: inALURes, isStore: inMemWrite};
                mBusy = 1'b1; mWaitCycles = 0;
                mReq = 1'b1; mWe = inMemWrite; mAddr = inALURes; mWData = inWriteData;
                mWbValid = 1'b0;
            end else if (inValid) begin
                mWbValid = 1'b1; mWbRegWrite = inRegWrite; mWbMemToReg = 1'b0;
                mWbRd = inRd; mWbALURes = inALURes;
            end else begin
                mWbValid = 1'b0;
            end
        end else begin
            mWaitCycles++;
            if (memReady) begin
                mBusy = 1'b0; mReq = 1'b0; mWbValid = 1'b1;
                mWbRegWrite = pend.regWrite && !pend.isStore;
                mWbMemToReg = !pend.isStore;
                if (!pend.isStore) mWbReadData = memRData;
                mWbRd = pend.rd; mWbALURes = pend.alu;
            end else if (TO_EN && mWaitCycles == TIMEOUT) begin
                mBusy = 1'b0; mReq = 1'b0; mWbValid = 1'b1; mWbRegWrite = 1'b0;
                mWbMemToReg = 1'b0; mWbRd = pend.rd; mWbALURes = pend.alu; mBusErr = 1'b1;
            end else begin
                mWbValid = 1'b0;
            end
        end
    end

    // Cycle compare: control outputs always, payloads only while they carry meaning.
    always @(posedge clk) begin
        #1;
        checkOutput("cyc_stallOut", 32'(stallOut), 32'(mBusy));
        checkOutput("cyc_memReq", 32'(memReq), 32'(mReq));
        checkOutput("cyc_wbValid", 32'(wbValid), 32'(mWbValid));
        checkOutput("cyc_busErr", 32'(busErr), 32'(mBusErr));
        if (mReq || mRstLast) begin
            checkOutput("cyc_memWe", 32'(memWe), 32'(mWe));
            checkOutput("cyc_memAddr", 32'(memAddr), 32'(mAddr));
            checkOutput("cyc_memWData", 32'(memWData), 32'(mWData));
        end
        if (mWbValid || mRstLast) begin
            checkOutput("cyc_wbRegWrite", 32'(wbRegWrite), 32'(mWbRegWrite));
            checkOutput("cyc_wbMemToReg", 32'(wbMemToReg), 32'(mWbMemToReg));
            checkOutput("cyc_wbRd", 32'(wbRd), 32'(mWbRd));
            checkOutput("cyc_wbReadData", 32'(wbReadData), 32'(mWbReadData));
            checkOutput("cyc_wbALURes", 32'(wbALURes), 32'(mWbALURes));
        end
    end

    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic rw,
                                 input logic [REG_W-1:0] dst, input logic [DATA_W-1:0] alu,
                                 input logic [DATA_W-1:0] wdata);
        inValid = v; inMemRead = rd; inMemWrite = wr; inRegWrite = rw;
        inRd = dst; inALURes = alu; inWriteData = wdata;
    endtask

    task automatic driveMem(input logic rdy, input logic [DATA_W-1:0] rdata);
        memReady = rdy; memRData = rdata;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    logic [REG_W-1:0]  aluRd [6] = '{3'd1, 3'd2, 3'd7, 3'd0, 3'd4, 3'd6};
    logic [DATA_W-1:0] aluVal[6] = '{8'h01, 8'hFF, 8'h80, 8'h00, 8'hA5, 8'h3C};

    initial begin
        rst = 1'b1;
        idle();
        driveMem(1'b0, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("rst_stallOut", 32'(stallOut), 32'd0);
        checkOutput("rst_memReq", 32'(memReq), 32'd0);
        checkOutput("rst_wbValid", 32'(wbValid), 32'd0);
        checkOutput("rst_busErr", 32'(busErr), 32'd0);
        rst = 1'b0;

        // ALU pass-through, one cycle latency.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'h5A, 8'h00);
        @(negedge clk);
        checkOutput("alu_wbValid", 32'(wbValid), 32'd1);
        checkOutput("alu_wbRd", 32'(wbRd), 32'd3);
        checkOutput("alu_wbALURes", 32'(wbALURes), 32'h5A);
        checkOutput("alu_wbMemToReg", 32'(wbMemToReg), 32'd0);
        checkOutput("alu_stallOut", 32'(stallOut), 32'd0);
        idle();

        // Load with three wait cycles before memReady.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'h10, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) idle();
            checkOutput("ld_stallOut", 32'(stallOut), 32'd1);
            checkOutput("ld_memReq", 32'(memReq), 32'd1);
            checkOutput("ld_memAddr", 32'(memAddr), 32'h10);
            if (k == 4) driveMem(1'b1, 8'hC3);
        end
        @(negedge clk);
        driveMem(1'b0, 8'h00);
        checkOutput("ld_doneStall", 32'(stallOut), 32'd0);
        checkOutput("ld_wbReadData", 32'(wbReadData), 32'hC3);
        checkOutput("ld_wbMemToReg", 32'(wbMemToReg), 32'd1);
        checkOutput("ld_wbRegWrite", 32'(wbRegWrite), 32'd1);
        checkOutput("ld_wbRd", 32'(wbRd), 32'd5);

        // Store with immediate memReady; the held ALU op enters one cycle after completion.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 8'h20, 8'h7E);
        @(negedge clk);
        checkOutput("st_memWe", 32'(memWe), 32'd1);
        checkOutput("st_memWData", 32'(memWData), 32'h7E);
        driveMem(1'b1, 8'hEE);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'h33, 8'h00);
        @(negedge clk);
        driveMem(1'b0, 8'h00);
        checkOutput("st_wbValid", 32'(wbValid), 32'd1);
        checkOutput("st_wbRegWrite", 32'(wbRegWrite), 32'd0);
        checkOutput("st_wbReadData", 32'(wbReadData), 32'hC3);
        @(negedge clk);
        idle();
        checkOutput("st_nextRd", 32'(wbRd), 32'd2);
        checkOutput("st_nextALU", 32'(wbALURes), 32'h33);

        // Read and write flags together act as a store.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 8'h44, 8'h99);
        @(negedge clk);
        idle();
        checkOutput("rw_memWe", 32'(memWe), 32'd1);
        driveMem(1'b1, 8'h12);
        @(negedge clk);
        driveMem(1'b0, 8'h00);
        checkOutput("rw_wbRegWrite", 32'(wbRegWrite), 32'd0);
        checkOutput("rw_wbMemToReg", 32'(wbMemToReg), 32'd0);

        // Back-to-back loads: the request drops for a cycle between them.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h50, 8'h00);
        @(negedge clk);
        driveMem(1'b1, 8'h11);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 8'h51, 8'h00);
        @(negedge clk);
        checkOutput("b2b_gapReq", 32'(memReq), 32'd0);
        driveMem(1'b0, 8'h00);
        @(negedge clk);
        idle();
        checkOutput("b2b_secondAddr", 32'(memAddr), 32'h51);
        driveMem(1'b1, 8'h22);
        @(negedge clk);
        driveMem(1'b0, 8'h00);
        checkOutput("b2b_secondData", 32'(wbReadData), 32'h22);

        // Consecutive ALU ops stream through with no stall.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, i[0], aluRd[i], aluVal[i], 8'h00);
            @(negedge clk);
            checkOutput("stream_wbALURes", 32'(wbALURes), 32'(aluVal[i]));
        end
        idle();

        // Reset held two cycles in the middle of a wait abandons the load.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'h77, 8'h00);
        repeat (2) @(negedge clk);
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstw_stallOut", 32'(stallOut), 32'd0);
        checkOutput("rstw_memAddr", 32'(memAddr), 32'd0);
        rst = 1'b0;
        driveMem(1'b1, 8'h55);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rstw_noWb", 32'(wbValid), 32'd0);
        end
        driveMem(1'b0, 8'h00);

`ifdef MEM_TIMEOUT_EN
        // memReady never arrives: abort after the fifteenth wait cycle, busErr sticks.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h90, 8'h00);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 1) idle();
        end
        checkOutput("to_reqLastCycle", 32'(memReq), 32'd1);
        @(negedge clk);
        checkOutput("to_reqDropped", 32'(memReq), 32'd0);
        checkOutput("to_busErr", 32'(busErr), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("to_busErrSticky", 32'(busErr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // memReady on the fifteenth wait cycle completes normally.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h91, 8'h00);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 1) idle();
            if (k == TIMEOUT) driveMem(1'b1, 8'h6D);
        end
        @(negedge clk);
        driveMem(1'b0, 8'h00);
        checkOutput("to_lateReadData", 32'(wbReadData), 32'h6D);
        checkOutput("to_noBusErr", 32'(busErr), 32'd0);
`else
        // Without the timeout the request simply persists.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h90, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) idle();
        end
        checkOutput("nto_reqHeld", 32'(memReq), 32'd1);
        checkOutput("nto_busErr", 32'(busErr), 32'd0);
        driveMem(1'b1, 8'h6D);
        @(negedge clk);
        driveMem(1'b0, 8'h00);
        checkOutput("nto_readData", 32'(wbReadData), 32'h6D);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
